// File: rtl/ixc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ixc_pkg
// Description : Shared types for the ixc skid buffer (state enum, occupancy).
// Revision    : 1.0 - initial release
// ============================================================================
package ixc_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    typedef logic [1:0] occ_t;

    // The state encoding doubles as the occupancy count.
    function automatic occ_t occ_of_state(input skid_state_t st);
        return occ_t'(st);
    endfunction

endpackage : ixc_pkg
`default_nettype wire

// File: rtl/ixc_skid_slot.sv
`default_nettype none
// ============================================================================
// Module      : ixc_skid_slot
// Description : W-bit data register with load enable and synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module ixc_skid_slot #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : ixc_skid_slot
`default_nettype wire

// File: rtl/ixc_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : ixc_skid_buf
// Description : Two-entry skid buffer (head/tail) with freeze gating and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module ixc_skid_buf
    import ixc_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    input  logic         freeze,
    input  logic         flush,
    output occ_t         count
);

    skid_state_t r_state;
    logic        w_push;
    logic        w_pop;
    logic        w_head_load;
    logic        w_tail_load;
    logic [W-1:0] w_head_d;
    logic [W-1:0] w_head_q;
    logic [W-1:0] w_tail_q;

    // Handshake flags depend only on state and freeze, never on the partner's signal.
    assign in_ready  = !freeze && (r_state != ST_FULL);
    assign out_valid = !freeze && (r_state != ST_EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        w_head_load = 1'b0;
        w_tail_load = 1'b0;
        w_head_d    = in_data;
        if (!flush) begin
            case (r_state)
                ST_EMPTY: w_head_load = w_push;
                ST_ONE: begin
                    w_head_load = w_push && w_pop;
                    w_tail_load = w_push && !w_pop;
                end
                ST_FULL: begin
                    w_head_load = w_pop;
                    w_head_d    = w_tail_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_push) r_state <= ST_ONE;
                ST_ONE: begin
                    if (w_push && !w_pop)      r_state <= ST_FULL;
                    else if (!w_push && w_pop) r_state <= ST_EMPTY;
                end
                ST_FULL:  if (w_pop) r_state <= ST_ONE;
                default:  r_state <= ST_EMPTY;
            endcase
        end
    end

    ixc_skid_slot #(.W(W)) u_head (
        .clk  (clk),
        .rst  (rst),
        .load (w_head_load),
        .d    (w_head_d),
        .q    (w_head_q)
    );

    ixc_skid_slot #(.W(W)) u_tail (
        .clk  (clk),
        .rst  (rst),
        .load (w_tail_load),
        .d    (in_data),
        .q    (w_tail_q)
    );

    assign out_data = w_head_q;
    assign count    = occ_of_state(r_state);

endmodule : ixc_skid_buf
`default_nettype wire

// File: tb/tb_ixc_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_ixc_skid_buf
// Description : Directed self-checking bench for ixc_skid_buf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ixc_skid_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_data = 3'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_data;
    logic       freeze = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ixc_skid_buf #(.W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .freeze    (freeze),
        .flush     (flush),
        .count     (count)
    );

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b0; freeze = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic push(input logic [2:0] d);
        in_valid = 1'b1; in_data = d; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 3'b000) begin errors++; $display("FAIL reset_out_data got %b exp 000", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_fill();
        do_reset();
        push(3'b101);
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL fill1_count got %0d exp 1", count); end
        checks++; if (out_valid !== 1'b1 || out_data !== 3'b101) begin
            errors++; $display("FAIL fill1_head got v=%b d=%b exp v=1 d=101", out_valid, out_data); end
        push(3'b011);
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL fill2_count got %0d exp 2", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill2_in_ready got %b exp 0", in_ready); end
        checks++; if (out_data !== 3'b101) begin errors++; $display("FAIL fill2_out_data got %b exp 101", out_data); end
        // Stalled head must not move.
        step(); step();
        checks++; if (out_data !== 3'b101 || count !== 2'd2) begin
            errors++; $display("FAIL stall_hold got d=%b c=%0d exp d=101 c=2", out_data, count); end
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        step();
        checks++; if (count !== 2'd1 || out_data !== 3'b011) begin
            errors++; $display("FAIL drain1 got c=%0d d=%b exp c=1 d=011", count, out_data); end
        step();
        checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL drain2 got c=%0d v=%b exp c=0 v=0", count, out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 3'(i);
            step();
            checks++; if (out_data !== 3'(i) || count !== 2'd1 || out_valid !== 1'b1) begin
                errors++; $display("FAIL stream_%0d got d=%b c=%0d v=%b exp d=%b c=1 v=1",
                                   i, out_data, count, out_valid, 3'(i)); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL stream_end_count got %0d exp 0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_freeze();
        do_reset();
        push(3'b110);
        freeze = 1'b1; in_valid = 1'b1; in_data = 3'b111; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL freeze_gate got r=%b v=%b exp r=0 v=0", in_ready, out_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (count !== 2'd1) begin errors++; $display("FAIL freeze_count_%0d got %0d exp 1", i, count); end
        end
        freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++; if (out_data !== 3'b110 || out_valid !== 1'b1) begin
            errors++; $display("FAIL freeze_release got d=%b v=%b exp d=110 v=1", out_data, out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        push(3'b001);
        push(3'b010);
        flush = 1'b1; in_valid = 1'b1; in_data = 3'b100; out_ready = 1'b1;
        step();
        idle();
        #1;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush got c=%0d v=%b r=%b exp c=0 v=0 r=1", count, out_valid, in_ready); end
        // Flush still wins while frozen.
        push(3'b111);
        freeze = 1'b1; flush = 1'b1;
        step();
        idle();
        #1;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_freeze got %0d exp 0", count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(3'b101);
        push(3'b011);
        rst = 1'b1; in_valid = 1'b1; in_data = 3'b110; out_ready = 1'b1;
        step();
        idle();
        #1;
        checks++; if (count !== 2'd0 || out_data !== 3'b000 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid got c=%0d d=%b v=%b exp c=0 d=000 v=0", count, out_data, out_valid); end
    endtask

    initial begin
        step();
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_freeze();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ixc_skid_buf
`default_nettype wire

// File: doc/ixc_skid_buf.md
IXC_SKID_BUF -- requirements
Module: ixc_skid_buf

Interface
REQ-001 SHALL have parameter W, default 3, the payload width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, upstream data valid.
REQ-005 SHALL have port in_ready, output, 1, buffer can accept data this cycle.
REQ-006 SHALL have port in_data, input, W, upstream payload.
REQ-007 SHALL have port out_valid, output, 1, head entry presented downstream.
REQ-008 SHALL have port out_ready, input, 1, downstream accepts head.
REQ-009 SHALL have port out_data, output, W, head payload; drives the R bus of the downstream ixc_assign stage.
REQ-010 SHALL have port freeze, input, 1, emulation hold; blocks all transfers while high.
REQ-011 SHALL have port flush, input, 1, synchronous discard of all contents.
REQ-012 SHALL have port count, output, 2, current occupancy (0..2).

Function
REQ-013 SHALL hold at most two entries in a head/tail register pair; FSM states EMPTY (count 0), ONE (count 1) and FULL (count 2).
REQ-014 SHALL define a push as in_valid && in_ready and a pop as out_valid && out_ready, both sampled at the clock edge.
REQ-015 SHALL drive in_ready = !freeze && (state != FULL), decoded from registers only; no combinational path from out_ready or in_valid.
REQ-016 SHALL drive out_valid = !freeze && (state != EMPTY), and out_data = head register.
REQ-017 SHALL use these transitions: EMPTY with push -> ONE; ONE with push only -> FULL; ONE with pop only -> EMPTY; ONE with push and pop -> ONE with head replaced by in_data; FULL with pop -> ONE with tail moved to head; FULL with push -> impossible (in_ready=0).
REQ-018 SHALL give a latency of one cycle: data pushed at edge N is visible on out_data/out_valid after edge N.
REQ-019 SHALL keep out_data stable while out_valid && !out_ready.
REQ-020 SHALL treat freeze as pure gating: no state, data or count change while freeze=1; contents are presented again unchanged when freeze falls.
REQ-021 SHALL, on flush=1, go to EMPTY at the next edge and ignore any same-cycle push or pop; flush overrides freeze.
REQ-022 SHALL preserve FIFO order; it never drops or duplicates an entry.
REQ-023 SHALL drive count = 0, 1 or 2 matching the state, and never 3.

Reset
REQ-024 SHALL, with rst=1 at an edge, force state EMPTY and count=0, so that out_valid=0.
REQ-025 SHALL reset the head and tail data registers to all-zeros, making out_data=0 after reset.
REQ-026 SHALL give rst priority over flush, freeze and any handshake, including mid-transfer; no entry survives.

Structure
REQ-027 SHALL take the state enum (EMPTY/ONE/FULL) and the 2-bit occupancy typedef from the shared package ixc_pkg.
REQ-028 SHALL instantiate one sub-module, ixc_skid_slot: a W-bit register with load enable and synchronous clear, used twice (head and tail).
REQ-029 SHALL be 120-400 lines of RTL, with no latches and no asynchronous logic.

Verification
REQ-030 SHALL cover fill: rst then push 3'b101 and 3'b011 with out_ready=0 -> count=2, in_ready=0, out_data=3'b101.
REQ-031 SHALL cover drain order: from FULL (101, 011), set out_ready=1 for two cycles -> pops 101 then 011, count 2->1->0, out_valid=0.
REQ-032 SHALL cover streaming: in_valid=out_ready=1 for 8 cycles with data 0..7 -> outputs 0..7 in order, one cycle late, count stays 1.
REQ-033 SHALL cover freeze: at count=1 (data 110), freeze=1 for 3 cycles with in_valid=out_ready=1 -> in_ready=out_valid=0 and count=1; after release out_data=110.
REQ-034 SHALL cover flush: at FULL, flush=1 together with push and pop -> next cycle count=0, out_valid=0, in_ready=1.
REQ-035 SHALL cover reset mid-operation: rst=1 at count=2 with in_valid=1 -> next cycle count=0, out_data=000, out_valid=0.
